pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 16: payload width in bits, legal range 1..256.
REQ-002 Parameter SKID, default 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
REQ-003 Parameter RESET_VAL, default 0: DATA_W-bit value loaded into both payload registers at reset.
REQ-004 Parameter CNT_W, default 16: stall counter width in bits, legal range 1..32.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous reset, active-low (0 = reset asserted).
REQ-007 flush  in  1  synchronous discard of all held entries.
REQ-008 in_valid  in  1  upstream offers in_data.
REQ-009 in_ready  out  1  block can accept in_data this cycle.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 out_valid  out  1  out_data holds a valid entry.
REQ-012 out_ready  in  1  downstream takes out_data this cycle.
REQ-013 out_data  out  DATA_W  head payload, driven directly from the main register.
REQ-014 occupancy  out  2  number of held entries (0..2).
REQ-015 clr_cnt  in  1  synchronous clear of stall_cycles.
REQ-016 stall_cycles  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-017 Accept = in_valid & in_ready; take = out_valid & out_ready; transfers occur only on these terms.
REQ-018 States: EMPTY (occupancy 0), HALF (1, main register valid), FULL (2, main and skid registers valid); out_valid = (state != EMPTY).
REQ-019 SKID=1: in_ready is a registered signal equal to (next state != FULL); it has no combinational path from out_ready.
REQ-020 EMPTY: accept -> HALF, main <= in_data.
REQ-021 HALF: accept & take -> HALF, main <= in_data; accept & ~take -> FULL, skid <= in_data; ~accept & take -> EMPTY; otherwise hold.
REQ-022 FULL: take -> HALF, main <= skid; otherwise hold; in_ready = 0, so no accept is possible.
REQ-023 SKID=0: FULL is unreachable; in_ready = ~out_valid | out_ready (combinational); HALF with accept & take reloads main.
REQ-024 Latency: an entry accepted at edge N is visible on out_data/out_valid after edge N (one cycle); FIFO order is preserved.
REQ-025 flush = 1 forces state to EMPTY at the next edge and overrides any simultaneous accept or take; payload registers are not modified.
REQ-026 SKID=1: in_ready is 1 in the cycle after a flush.
REQ-027 stall_cycles increments by 1 on each edge where out_valid & ~out_ready, including the cycle flush is asserted.
REQ-028 stall_cycles saturates at 2^CNT_W-1 and does not wrap.
REQ-029 clr_cnt = 1 sets stall_cycles to 0 at the next edge and takes priority over the increment.
REQ-030 out_data is don't-care while out_valid = 0; the bench shall not check it then.

Reset
REQ-031 rst = 0 immediately and asynchronously forces: state EMPTY, out_valid 0, occupancy 0, stall_cycles 0, main and skid registers = RESET_VAL, in_ready = 0 (SKID=1) or 1 (SKID=0).
REQ-032 SKID=1: in_ready rises at the first clk edge after rst deasserts.
REQ-033 Reset asserted mid-transfer discards all entries with no partial update.

Verification
REQ-034 SKID=1, DATA_W=16: send 0x1111, 0x2222 back-to-back with out_ready=0 -> occupancy 2, in_ready 0, out_data 0x1111; raise out_ready for 2 cycles -> outputs 0x1111 then 0x2222, then EMPTY.
REQ-035 Streaming: in_valid=out_ready=1 with data 1,2,3,... -> out_data equals the input delayed by one cycle, occupancy stays 1, in_ready stays 1.
REQ-036 Flush in FULL with simultaneous in_valid=1 and out_ready=1 -> next cycle out_valid 0, occupancy 0, the offered word is dropped, and in_ready 1.
REQ-037 CNT_W=3, out_valid held with out_ready=0 for 10 cycles -> stall_cycles reads 7; clr_cnt pulse -> 0.
REQ-038 SKID=0: out_valid=1, out_ready=0 -> in_ready 0; raise out_ready with in_valid=1 and data 0xABCD -> next cycle out_data 0xABCD, out_valid 1.
REQ-039 Drive rst low asynchronously (between edges) while FULL -> all outputs reach their reset values before the next edge; after release, in_ready is 1 one edge later.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Single-stage valid/ready pipeline register with optional 2-entry skid buffer
// and a saturating back-pressure (stall) counter.
module pipe_stage_skid #(
    parameter int unsigned          DATA_W    = 16,
    parameter bit                   SKID      = 1'b1,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, skid_q;
    logic                in_ready_q;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic accept, take;
    logic load_main_in, load_main_skid, load_skid;

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign occupancy = 2'(state_q);

    // Without the skid register the stage can only accept when its slot frees up this cycle.
    assign in_ready = SKID ? in_ready_q : (!out_valid || out_ready);

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d      = StHalf;
                    load_main_in = 1'b1;
                end
            end
            StHalf: begin
                if (accept && take) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = StFull;
                    load_skid = 1'b1;
                end else if (take) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (take) begin
                    state_d        = StHalf;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops every entry but leaves the payload registers untouched.
        if (flush) begin
            state_d        = StEmpty;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (clr_cnt) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
            in_ready_q <= (state_d != StFull);
            stall_q    <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (skid, skid with 3-bit counter, no skid)
// driven in parallel and compared every cycle against a queue-level model.
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        clr_cnt;

    logic        rdy_a, rdy_b, rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic [1:0]  occ_a, occ_b, occ_c;
    logic [15:0] od_a, od_b, od_c;
    logic [15:0] sc_a, sc_c;
    logic [2:0]  sc_b;

    pipe_stage_skid #(.DATA_W(16), .SKID(1'b1), .RESET_VAL(16'hBEEF), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .occupancy(occ_a), .clr_cnt(clr_cnt), .stall_cycles(sc_a)
    );

    pipe_stage_skid #(.DATA_W(16), .SKID(1'b1), .RESET_VAL(16'h0000), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
        .occupancy(occ_b), .clr_cnt(clr_cnt), .stall_cycles(sc_b)
    );

    pipe_stage_skid #(.DATA_W(16), .SKID(1'b0), .RESET_VAL(16'h0000), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
        .occupancy(occ_c), .clr_cnt(clr_cnt), .stall_cycles(sc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each instance is a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [15:0] m_data [3][2];
    int          m_n     [3] = '{0, 0, 0};
    bit          m_rdy   [3] = '{1'b0, 1'b0, 1'b0};
    int unsigned m_stall [3] = '{0, 0, 0};
    int unsigned m_max   [3] = '{65535, 7, 65535};

    function automatic bit is_skid(input int i);
        return (i != 2);
    endfunction

    function automatic bit exp_rdy(input int i);
        if (is_skid(i)) return m_rdy[i];
        return (m_n[i] == 0) || out_ready;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_n[i]     = 0;
                m_rdy[i]   = 1'b0;
                m_stall[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit acc, tk;
                acc = in_valid && exp_rdy(i);
                tk  = (m_n[i] > 0) && out_ready;
                if (clr_cnt) m_stall[i] = 0;
                else if (m_n[i] > 0 && !out_ready && m_stall[i] < m_max[i]) m_stall[i]++;
                if (flush) begin
                    m_n[i] = 0;
                end else begin
                    if (tk) begin
                        m_data[i][0] = m_data[i][1];
                        m_n[i]--;
                    end
                    if (acc) begin
                        m_data[i][m_n[i]] = in_data;
                        m_n[i]++;
                    end
                end
                m_rdy[i] = (m_n[i] < 2);
            end
        end
    end

    function automatic logic [31:0] dut_field(input int i, input int f);
        logic [31:0] r;
        r = '0;
        case (i)
            0: case (f) 0: r = 32'(rdy_a); 1: r = 32'(ov_a); 2: r = 32'(occ_a);
                        3: r = 32'(od_a); default: r = 32'(sc_a); endcase
            1: case (f) 0: r = 32'(rdy_b); 1: r = 32'(ov_b); 2: r = 32'(occ_b);
                        3: r = 32'(od_b); default: r = 32'(sc_b); endcase
            default: case (f) 0: r = 32'(rdy_c); 1: r = 32'(ov_c); 2: r = 32'(occ_c);
                        3: r = 32'(od_c); default: r = 32'(sc_c); endcase
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d in_ready", i), dut_field(i, 0), 32'(exp_rdy(i)));
                chk($sformatf("u%0d out_valid", i), dut_field(i, 1), 32'(m_n[i] > 0));
                chk($sformatf("u%0d occupancy", i), dut_field(i, 2), 32'(m_n[i]));
                if (m_n[i] > 0)
                    chk($sformatf("u%0d out_data", i), dut_field(i, 3), 32'(m_data[i][0]));
                chk($sformatf("u%0d stall_cycles", i), dut_field(i, 4), m_stall[i]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; clr_cnt = 1'b0;
        chk_en = 1'b1;
        repeat (2) step();

        // Reset state
        chk("reset a in_ready", 32'(rdy_a), 32'd0);
        chk("reset a out_valid", 32'(ov_a), 32'd0);
        chk("reset a occupancy", 32'(occ_a), 32'd0);
        chk("reset a stall", 32'(sc_a), 32'd0);
        chk("reset c in_ready", 32'(rdy_c), 32'd1);
        rst = 1'b1;
        step();
        chk("a in_ready after release", 32'(rdy_a), 32'd1);

        // Two words back-to-back into a stalled stage, then drain
        in_valid = 1'b1; in_data = 16'h1111; out_ready = 1'b0;
        step();
        in_data = 16'h2222;
        step();
        in_valid = 1'b0;
        chk("full occupancy", 32'(occ_a), 32'd2);
        chk("full in_ready", 32'(rdy_a), 32'd0);
        chk("full head", 32'(od_a), 32'h1111);
        out_ready = 1'b1;
        step();
        chk("drain second", 32'(od_a), 32'h2222);
        chk("drain occupancy", 32'(occ_a), 32'd1);
        step();
        chk("drained out_valid", 32'(ov_a), 32'd0);
        chk("drained occupancy", 32'(occ_a), 32'd0);
        out_ready = 1'b0;
        step();

        // Streaming
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k > 1) begin
                chk("stream data", 32'(od_a), 32'(k - 1));
                chk("stream occupancy", 32'(occ_a), 32'd1);
                chk("stream in_ready", 32'(rdy_a), 32'd1);
            end
            in_valid = 1'b1; out_ready = 1'b1; in_data = 16'(k);
        end
        step();
        in_valid = 1'b0;
        step();

        // Flush while full with a simultaneous offer and take
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h3333;
        step();
        in_data = 16'h4444;
        step();
        chk("pre-flush occupancy", 32'(occ_a), 32'd2);
        in_data = 16'h5555; out_ready = 1'b1; flush = 1'b1;
        step();
        chk("flush out_valid", 32'(ov_a), 32'd0);
        chk("flush occupancy", 32'(occ_a), 32'd0);
        chk("flush in_ready", 32'(rdy_a), 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("flush dropped word", 32'(occ_a), 32'd0);

        // Stall counter saturation on the 3-bit instance
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0; in_valid = 1'b1; in_data = 16'h7777;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        chk("b stall saturated", 32'(sc_b), 32'd7);
        clr_cnt = 1'b1;
        step();
        chk("b stall cleared", 32'(sc_b), 32'd0);
        clr_cnt = 1'b0;

        // No-skid instance: combinational in_ready and reload on accept+take
        chk("c in_ready stalled", 32'(rdy_c), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hABCD;
        #1;
        chk("c in_ready comb", 32'(rdy_c), 32'd1);
        step();
        chk("c reload data", 32'(od_c), 32'hABCD);
        chk("c reload valid", 32'(ov_c), 32'd1);

        // Asynchronous reset while full
        in_data = 16'h0BEE; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("a full before reset", 32'(occ_a), 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst out_valid", 32'(ov_a), 32'd0);
        chk("async rst occupancy", 32'(occ_a), 32'd0);
        chk("async rst in_ready", 32'(rdy_a), 32'd0);
        chk("async rst stall", 32'(sc_a), 32'd0);
        chk("async rst c in_ready", 32'(rdy_c), 32'd1);
        step();
        rst = 1'b1;
        chk("a in_ready held after release", 32'(rdy_a), 32'd0);
        step();
        chk("a in_ready one edge later", 32'(rdy_a), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step();
            rst       = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            clr_cnt   = ($urandom_range(0, 49) == 0);
            in_data   = 16'($urandom);
        end
        step();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; clr_cnt = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
